// File: rtl/dpram_responder.sv
`default_nettype none
// ============================================================================
// Module   : dpram_responder
// Purpose  : 1024 x 16 dual-port memory. Port A is a four-phase strobe/Done
//            read/write responder with programmable wait states; port B is a
//            free-running synchronous read port.
// Ports    : clk     - single clock, rising edge
//            ar      - synchronous active-high reset
//            A/DIn   - port-A address / write data, latched at acceptance
//            RD/WR   - port-A level strobes, held until Done
//            DOut    - port-A read data (registered)
//            Done    - port-A completion (registered, four-phase)
//            Err     - RD and WR both high at acceptance; valid with Done
//            B_A     - port-B read address, sampled every cycle
//            B_DOut  - port-B read data (registered, 1-cycle latency)
// Revision : 1.0 - initial release
// ============================================================================
module dpram_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH       = 1024
) (
  input  logic        clk,
  input  logic        ar,
  input  logic [9:0]  A,
  input  logic [15:0] DIn,
  input  logic        RD,
  input  logic        WR,
  output logic [15:0] DOut,
  output logic        Done,
  output logic        Err,
  input  logic [9:0]  B_A,
  output logic [15:0] B_DOut
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [9:0]  a_lat;
  logic [15:0] din_lat;
  logic        rd_lat;
  logic        wr_lat;
  logic        armed;

  logic [15:0] mem [DEPTH];

  logic        strobe;
  logic [9:0]  a_idx;
  logic [9:0]  b_idx;
  logic        do_write;

  assign strobe = RD | WR;

  // Addresses wrap modulo DEPTH so a non-power-of-two depth stays in range.
  assign a_idx = 10'(32'(a_lat) % DEPTH);
  assign b_idx = 10'(32'(B_A) % DEPTH);

  // A conflicting RD+WR request never touches memory, and a reset landing
  // on the commit edge cancels the write.
  assign do_write = (state == S_ACCESS) && wr_lat && !rd_lat && !ar;

  // Storage is deliberately not reset so contents survive ar.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[a_idx] <= din_lat;
    end
  end

  always_ff @(posedge clk) begin
    if (ar) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      a_lat   <= 10'd0;
      din_lat <= 16'h0000;
      rd_lat  <= 1'b0;
      wr_lat  <= 1'b0;
      armed   <= 1'b0;
      Done    <= 1'b0;
      Err     <= 1'b0;
      DOut    <= 16'h0000;
      B_DOut  <= 16'h0000;
    end else begin
      // Port B reads the pre-write contents when it collides with port A.
      B_DOut <= mem[b_idx];

      // A strobe left high through reset is not a new request; the
      // initiator must drop both strobes before anything is accepted.
      if (!strobe) begin
        armed <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (strobe && armed) begin
            a_lat   <= A;
            din_lat <= DIn;
            rd_lat  <= RD;
            wr_lat  <= WR;
            cnt     <= 4'd0;
            state   <= S_WAIT;
          end
        end
        // WAIT always includes one decode cycle ahead of the programmed
        // idle cycles, giving Done WAIT_CYCLES+2 edges after acceptance.
        S_WAIT: begin
          if (cnt == WAIT_LAST) begin
            state <= S_ACCESS;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_ACCESS: begin
          Done  <= 1'b1;
          state <= S_HOLD;
          if (rd_lat && wr_lat) begin
            Err <= 1'b1;
          end else if (rd_lat) begin
            DOut <= mem[a_idx];
          end
        end
        S_HOLD: begin
          if (!strobe) begin
            Done  <= 1'b0;
            Err   <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
